bitwise_logic_unit: RTL and testbench
=====================================

# bitwise_logic_unit

- Parametrised, pipelined bitwise logic unit: successor to the single-operation bit-wise NOT.
- Applies one of eight bit-wise operations to two N-bit operands and registers the result with reduction flags.
- Streams operands through a valid/ready handshake at up to one result per clock.
- Sits between operand sources and downstream consumers in the BasicCombinationalLogic datapath, where back-pressure must be honoured.

## Interface
Parameters:
- N, 8, operand/result width in bits (N ≥ 1).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit accepts a beat this cycle.
- op  input  3  operation select, sampled with the beat.
- a  input  N  operand A.
- b  input  N  operand B (ignored for NOT/PASS).
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result this cycle.
- c  output  N  result.
- red_and  output  1  &c.
- red_or  output  1  |c (0 means result is zero).
- red_xor  output  1  ^c (odd parity).

## Operation
- Input handshake:
  - A beat transfers when in_valid && in_ready at a rising edge.
  - op, a and b are sampled only on transfer.
- Output handshake:
  - A beat retires when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, c, red_* and out_valid hold stable.
- op encoding:
  - 000 ~a
  - 001 a&b
  - 010 a|b
  - 011 a^b
  - 100 ~(a&b)
  - 101 ~(a|b)
  - 110 ~(a^b)
  - 111 a (pass)
- Result width is exactly N. No carry or extension.
- Reduction flags are computed from the result and registered in the same stage as c, so they always describe the presented c.
- Storage: output register, plus an optional skid register (see Configuration). Beats leave in acceptance order. No beat is dropped or duplicated.
- Reset (rst=1 at an edge):
  - out_valid=0, c=0, red_and=0, red_or=0, red_xor=0.
  - Skid storage is emptied.
  - in_ready=0 combinationally while rst=1.
  - An in-flight beat is discarded. There is no partial retire.
- out_ready with out_valid=0 has no effect.

## Timing
- Latency: a beat accepted at edge k appears on c with out_valid=1 after edge k (1 cycle).
- Throughput: 1 beat/clock when out_ready is held high, in both configurations.
- Simultaneous accept and retire in the same cycle:
  - The output register reloads with the new beat.
  - out_valid stays 1 with no bubble.
- First edge after rst deasserts: in_ready=1 and the unit is empty.

## Configuration
- Macro: BITWISE_LOGIC_SKID_EN.
- Defined (registered ready):
  - Two-entry buffer: output register plus one skid register.
  - in_ready = ~skid_valid, driven from a flop with no combinational path from out_ready.
  - A beat accepted while out_valid=1 and out_ready=0 goes to the skid register, and in_ready drops the next cycle.
  - On retire, the skid entry moves to the output register the same edge.
  - Maximum occupancy is 2.
- Undefined:
  - Single output register only.
  - in_ready = ~rst & (~out_valid | out_ready), a combinational path from out_ready.
  - Maximum occupancy is 1.
- Handshake semantics, ordering, latency and reset values are identical in both builds.

## Test plan
All scenarios use N=8.
- Op sweep: a=8'hA5, b=8'h3C, op 000..111, out_ready=1. Required c, one per cycle with 1-cycle latency:
  - 5A, 24, BD, 99, DB, 42, 66, A5
  - red_xor follows the parity of each c: 0,0,0,0,0,0,0,0; verify per beat.
- Flags: op=001, a=8'hFF, b=8'hFF → c=FF, red_and=1, red_or=1, red_xor=0. op=011, a=b=8'h5A → c=00, red_or=0, red_and=0.
- Back-pressure: stream 4 beats (op=000, a=01,02,03,04) with out_ready=0 for 3 cycles, then 1.
  - Skid build: 2 beats held and in_ready=0 from the cycle after the second accept.
  - Non-skid build: in_ready=0 after the first accept.
  - Both builds: outputs FE, FD, FC, FB in order, none lost.
- Full throughput: 16 back-to-back beats with out_ready=1 → 16 results on 16 consecutive cycles, out_valid never drops.
- Reset mid-stream: assert rst for one cycle while out_valid=1 and the skid is full → next cycle out_valid=0, c=00, all flags 0; the following beat produces the correct result with no stale data.
- Stall stability: hold out_ready=0 for 5 cycles with out_valid=1 while a, b and op toggle randomly → c and flags unchanged throughout.

Source files
------------

// File: rtl/bitwise_logic_unit.sv
// ============================================================================
// bitwise_logic_unit
// ----------------------------------------------------------------------------
// Pipelined bit-wise logic unit. It applies one of eight bit-wise operations
// to two N-bit operands and registers the result together with its reduction
// flags. Operands arrive over a valid/ready handshake and results leave over
// a second valid/ready handshake. Both handshakes run at up to one beat per
// clock, and the unit honours back-pressure from the consumer.
//
// Build option (macro BITWISE_LOGIC_SKID_EN):
//   undefined : single output register. in_ready depends combinationally on
//               out_ready, so at most one beat is in flight.
//   defined   : output register plus one skid register. in_ready comes from
//               a flop (~skid_valid) and has no combinational path from
//               out_ready, so at most two beats are in flight.
//   Ordering, latency and reset values are the same in both builds.
//
// Parameters:
//   N          operand/result width in bits (N >= 1)
//
// Ports:
//   clk        sole clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat present
//   in_ready   unit accepts a beat this cycle (0 while rst=1)
//   op[2:0]    operation select, sampled with the beat
//   a[N-1:0]   operand A
//   b[N-1:0]   operand B (ignored for NOT and PASS)
//   out_valid  result beat present
//   out_ready  consumer accepts the result this cycle
//   c[N-1:0]   result
//   red_and    &c
//   red_or     |c (0 means the result is zero)
//   red_xor    ^c (odd parity)
// ============================================================================
module bitwise_logic_unit #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         red_and,
    output logic         red_or,
    output logic         red_xor
);

    // ------------------------------------------------------------------------
    // Types
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        OP_NOT  = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_XOR  = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_XNOR = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    // A stored beat: the result plus the flags that describe it. Keeping them
    // together means the flags can never disagree with the presented c.
    typedef struct packed {
        logic [N-1:0] data;
        logic         f_and;
        logic         f_or;
        logic         f_xor;
    } beat_t;

    // ------------------------------------------------------------------------
    // Combinational datapath: operation and reduction flags
    // ------------------------------------------------------------------------
    op_e          op_sel;
    logic [N-1:0] result;
    beat_t        new_beat;

    assign op_sel = op_e'(op);

    // NOTE: every signal written in an always_comb gets a default first, so
    //       no path through the block can leave it unassigned (no latch).
    always_comb begin
        result = '0;
        case (op_sel)
            OP_NOT:  result = ~a;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_XNOR: result = ~(a ^ b);
            OP_PASS: result = a;
            default: result = '0;
        endcase
    end

    always_comb begin
        new_beat       = '0;
        new_beat.data  = result;
        new_beat.f_and = &result;
        new_beat.f_or  = |result;
        new_beat.f_xor = ^result;
    end

    // ------------------------------------------------------------------------
    // Handshake events
    // ------------------------------------------------------------------------
    beat_t out_q;
    logic  out_valid_q;
    logic  accept;   // operand beat transfers at this edge
    logic  retire;   // result beat leaves at this edge

    assign accept = in_valid & in_ready;
    assign retire = out_valid_q & out_ready;

`ifdef BITWISE_LOGIC_SKID_EN
    // ------------------------------------------------------------------------
    // Two-entry build: output register plus skid register
    // ------------------------------------------------------------------------
    beat_t skid_q;
    logic  skid_valid_q;

    // in_ready is a pure flop output (gated only by reset), so the upstream
    // source never sees a combinational path from out_ready.
    assign in_ready = ~rst & ~skid_valid_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    //       samples the values from before the edge, whatever the order of
    //       statements in the block.
    // NOTE: the data registers are reset too, because c and the flags must
    //       read zero after reset, not only out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            if (!out_valid_q || retire) begin
                // The output slot is free at this edge. An older beat held in
                // the skid register moves up first so order is kept. While the
                // skid is full in_ready is 0, so no new beat competes for it.
                if (skid_valid_q) begin
                    out_q        <= skid_q;
                    skid_valid_q <= 1'b0;
                end else if (accept) begin
                    out_q       <= new_beat;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (accept) begin
                // The output is stalled, so the new beat parks in the skid
                // register and in_ready drops on the following cycle.
                skid_q       <= new_beat;
                skid_valid_q <= 1'b1;
            end
        end
    end
`else
    // ------------------------------------------------------------------------
    // Single-register build
    // ------------------------------------------------------------------------
    // Ready whenever the output register is empty or being drained this cycle.
    // This path is combinational from out_ready.
    assign in_ready = ~rst & (~out_valid_q | out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            // An accept in the same cycle as a retire reloads the register
            // directly, so out_valid stays high with no bubble.
            out_q       <= new_beat;
            out_valid_q <= 1'b1;
        end else if (retire) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Outputs: driven straight from the output register
    // ------------------------------------------------------------------------
    assign out_valid = out_valid_q;
    assign c         = out_q.data;
    assign red_and   = out_q.f_and;
    assign red_or    = out_q.f_or;
    assign red_xor   = out_q.f_xor;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// ============================================================================
// tb_bitwise_logic_unit
// ----------------------------------------------------------------------------
// Self-checking bench for bitwise_logic_unit with N=8. A reference model is
// built from per-bit truth tables and population counts. A queue of expected
// beats tracks what the unit holds. The bench runs directed scenarios, then a
// randomized handshake stream. It works in either build of the unit.
// ============================================================================
module tb_bitwise_logic_unit;

    localparam int N = 8;
`ifdef BITWISE_LOGIC_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic         red_and;
    logic         red_or;
    logic         red_xor;

    always #5 clk = ~clk;

    bitwise_logic_unit #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .red_and   (red_and),
        .red_or    (red_or),
        .red_xor   (red_xor)
    );

    typedef struct {
        logic [N-1:0] c;
        logic         f_and;
        logic         f_or;
        logic         f_xor;
    } exp_t;

    int           total = 0;
    int           bad   = 0;
    exp_t         exp_q[$];
    logic [N-1:0] got_q[$];
    logic         last_acc;
    logic         last_ov;

    // Truth table per op, 4 bits each. Bit {a_i,b_i} of the nibble is the
    // output bit. op0 ~a=3, op1 and=8, op2 or=E, op3 xor=6, op4 nand=7,
    // op5 nor=1, op6 xnor=9, op7 pass=C.
    logic [31:0] truth = 32'hC917_6E83;

    function automatic exp_t model(input logic [2:0] o, input logic [N-1:0] x,
                                   input logic [N-1:0] y);
        exp_t       e;
        logic [3:0] tt;
        int         ones;
        tt   = truth[4*o +: 4];
        ones = 0;
        for (int i = 0; i < N; i++) begin
            e.c[i] = tt[{x[i], y[i]}];
            ones += int'(e.c[i]);
        end
        e.f_and = (ones == N);
        e.f_or  = (ones > 0);
        e.f_xor = (ones % 2) == 1;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive the inputs, check the settled outputs against
    // the model, clock the design and update the model.
    task automatic cycle(input logic v, input logic [2:0] o, input logic [N-1:0] x,
                         input logic [N-1:0] y, input logic ordy, input logic r);
        logic exp_ready;
        rst       = r;
        in_valid  = v;
        op        = o;
        a         = x;
        b         = y;
        out_ready = ordy;
        #1;
        if (r) begin
            check("ready_in_rst", 32'(in_ready), 32'd0);
        end else begin
            exp_ready = (CAP == 2) ? (exp_q.size() < 2)
                                   : (exp_q.size() == 0 || ordy);
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("c", 32'(c), 32'(exp_q[0].c));
                check("red_and", 32'(red_and), 32'(exp_q[0].f_and));
                check("red_or", 32'(red_or), 32'(exp_q[0].f_or));
                check("red_xor", 32'(red_xor), 32'(exp_q[0].f_xor));
            end
        end
        last_acc = in_valid && in_ready;
        last_ov  = out_valid;
        if (out_valid && out_ready) got_q.push_back(c);
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
        end else begin
            if (last_ov && ordy) void'(exp_q.pop_front());
            if (last_acc) exp_q.push_back(model(o, x, y));
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 3'($urandom), N'($urandom), N'($urandom), ordy, 1'b0);
    endtask

    logic [N-1:0] sweep_exp [8];
    logic [N-1:0] bp_exp [4];

    initial begin
        int           k;
        logic [N-1:0] cap_c;
        logic [2:0]   cap_f;

        sweep_exp = '{8'h5A, 8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66, 8'hA5};
        bp_exp    = '{8'hFE, 8'hFD, 8'hFC, 8'hFB};
        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;

        // ---- Reset ----
        cycle(1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_c", 32'(c), 32'd0);
        check("rst_flags", {29'd0, red_and, red_or, red_xor}, 32'd0);

        // ---- Op sweep: one result per cycle, 1-cycle latency ----
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 3'(i), 8'hA5, 8'h3C, 1'b1, 1'b0);
            check("sweep_c", 32'(c), 32'(sweep_exp[i]));
            check("sweep_xor", 32'(red_xor), 32'd0);
        end
        idle(1'b1);

        // ---- Flags ----
        cycle(1'b1, 3'b001, 8'hFF, 8'hFF, 1'b1, 1'b0);
        check("flag_ff_c", 32'(c), 32'hFF);
        check("flag_ff", {29'd0, red_and, red_or, red_xor}, 32'b110);
        cycle(1'b1, 3'b011, 8'h5A, 8'h5A, 1'b1, 1'b0);
        check("flag_00_c", 32'(c), 32'h00);
        check("flag_00", {29'd0, red_and, red_or}, 32'b00);
        idle(1'b1);

        // ---- Back-pressure: 4 beats, out_ready low for 3 cycles ----
        got_q.delete();
        k = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            cycle(k < 4, 3'b000, N'(k + 1), 8'h00, cyc >= 3, 1'b0);
            if (last_acc) k++;
        end
        check("bp_accepted", 32'(k), 32'd4);
        check("bp_retired", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) check("bp_order", 32'(got_q[i]), 32'(bp_exp[i]));
        end

        // ---- Full throughput: 16 back-to-back beats ----
        got_q.delete();
        for (int i = 0; i < 17; i++) begin
            cycle(i < 16, 3'($urandom), N'($urandom), N'($urandom), 1'b1, 1'b0);
            if (i >= 1) check("tput_ov", 32'(last_ov), 32'd1);
        end
        check("tput_count", 32'(got_q.size()), 32'd16);
        idle(1'b1);

        // ---- Reset mid-stream with the unit full ----
        cycle(1'b1, 3'b000, 8'h11, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 3'b000, 8'h22, 8'h00, 1'b0, 1'b0);
        check("full_ov", 32'(out_valid), 32'd1);
        check("full_occ", 32'(exp_q.size()), 32'(CAP));
        cycle(1'b1, 3'b000, 8'h33, 8'h00, 1'b0, 1'b1);
        check("mrst_ov", 32'(out_valid), 32'd0);
        check("mrst_c", 32'(c), 32'd0);
        check("mrst_flags", {29'd0, red_and, red_or, red_xor}, 32'd0);
        cycle(1'b1, 3'b010, 8'h0F, 8'hF0, 1'b0, 1'b0);
        check("post_rst_c", 32'(c), 32'hFF);
        idle(1'b1);
        idle(1'b1);

        // ---- Stall stability ----
        cycle(1'b1, 3'b100, 8'hC3, 8'h81, 1'b0, 1'b0);
        cap_c = c;
        cap_f = {red_and, red_or, red_xor};
        check("stall_load", 32'(c), 32'h7E);
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            check("stall_c", 32'(c), 32'(cap_c));
            check("stall_flags", 32'({red_and, red_or, red_xor}), 32'(cap_f));
            check("stall_ov", 32'(out_valid), 32'd1);
        end
        idle(1'b1);

        // ---- Randomized handshake stream ----
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 3'($urandom), N'($urandom),
                  N'($urandom), 1'($urandom_range(0, 3) != 0),
                  $urandom_range(0, 63) == 0);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("drained", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
